// File: rtl/mult_pkg.sv
// Shared constants, FSM state and Booth opcode encoding for the sequential
// radix-2 Booth multiplier.
package mult_pkg;

  localparam int MULT_W       = 32;
  localparam int MULT_STATE_W = 2 * MULT_W + 1;
  localparam int MULT_ITER    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Booth recoding of {multiplier bit, previous multiplier bit} = P[1:0].
  typedef enum logic [1:0] {
    BOOTH_NOP0 = 2'b00,
    BOOTH_ADD  = 2'b01,
    BOOTH_SUB  = 2'b10,
    BOOTH_NOP1 = 2'b11
  } booth_op_t;

  // The 64-bit product fits in signed 32 bits only if its upper half is a
  // pure sign extension of bit 31 of the low half.
  function automatic logic prod_ovf(input logic [MULT_STATE_W-1:0] p);
    return p[MULT_STATE_W-1:MULT_W+1] != {MULT_W{p[MULT_W]}};
  endfunction

endpackage

// File: rtl/mult_booth_step.sv
// One combinational Booth iteration: 33-bit add/sub of the multiplicand into
// the upper half of P, then an arithmetic right shift of the whole state.
module mult_booth_step
  import mult_pkg::*;
(
  input  logic [MULT_STATE_W-1:0] p,
  input  logic [MULT_W-1:0]       m,
  output logic [MULT_STATE_W-1:0] p_next
);

  logic [MULT_W:0] upper_x;
  logic [MULT_W:0] m_x;
  logic [MULT_W:0] sum;

  // NOTE: every always_comb output gets a value on every path (default first),
  // otherwise synthesis infers a latch.
  always_comb begin
    upper_x = {p[MULT_STATE_W-1], p[MULT_STATE_W-1:MULT_W+1]};
    m_x     = {m[MULT_W-1], m};
    sum     = upper_x;
    case (booth_op_t'(p[1:0]))
      BOOTH_ADD: sum = upper_x + m_x;
      BOOTH_SUB: sum = upper_x - m_x;
      default:   sum = upper_x;
    endcase
    // The extra sum bit lands in P[64], keeping M = 0x80000000 exact.
    p_next = {sum, p[MULT_W:1]};
  end

endmodule

// File: rtl/mult_booth_seq.sv
// Sequential radix-2 Booth multiplier: 32 iterations per start, one-cycle RDY.
// Optional overflow detection is built only when MULT_OVF_EN is defined.
module mult_booth_seq
  import mult_pkg::*;
(
  input  logic              clock,
  input  logic              clr_n,
  input  logic [MULT_W-1:0] data_operandA,
  input  logic [MULT_W-1:0] data_operandB,
  input  logic              ctrl_MULT,
  output logic [MULT_W-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY,
  output logic              busy
);

  localparam logic [4:0] LAST_ITER = 5'(MULT_ITER - 1);

  mult_state_t             state;
  logic [MULT_W-1:0]       m;
  logic [MULT_STATE_W-1:0] p;
  logic [MULT_STATE_W-1:0] p_next;
  logic [4:0]              cnt;

  mult_booth_step u_step (
    .p      (p),
    .m      (m),
    .p_next (p_next)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state          <= IDLE;
      m              <= '0;
      p              <= '0;
      cnt            <= '0;
      data_result    <= '0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        // A new start aborts any run in progress without issuing RDY.
        m     <= data_operandA;
        p     <= {{MULT_W{1'b0}}, data_operandB, 1'b0};
        cnt   <= '0;
        state <= RUN;
        busy  <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            p   <= p_next;
            cnt <= cnt + 5'd1;
            if (cnt == LAST_ITER) begin
              state          <= DONE;
              busy           <= 1'b0;
              data_resultRDY <= 1'b1;
              data_result    <= p_next[MULT_W:1];
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef MULT_OVF_EN
  // Exception is captured on the same edge as the result and held with it.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      data_exception <= 1'b0;
    end else if (!ctrl_MULT && state == RUN && cnt == LAST_ITER) begin
      data_exception <= prod_ovf(p_next);
    end
  end
`else
  assign data_exception = 1'b0;
`endif

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed bench for mult_booth_seq: products, latency, abort/restart, reset.
// Expected exception values follow the MULT_OVF_EN build option.
module tb_mult_booth_seq;

`ifdef MULT_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clock;
  logic        clr_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mult_booth_seq dut (
    .clock          (clock),
    .clr_n          (clr_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse ctrl_MULT across one rising edge; returns at the negedge after it.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
  endtask

  // Counts rising edges after the start edge until RDY shows; -1 on timeout.
  task automatic wait_rdy(output int lat);
    lat = 0;
    while (!data_resultRDY && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    if (!data_resultRDY) lat = -1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    ctrl_MULT = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    total++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      bad++;
      $display("FAIL reset: res=%h exc=%b rdy=%b busy=%b want all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
    clr_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    int lat;
    do_start(32'd3, 32'd4);
    total++;
    if (busy !== 1'b1 || data_result !== 32'd0) begin
      bad++;
      $display("FAIL basic_run: busy=%b res=%h want busy=1 res=0", busy, data_result);
    end
    wait_rdy(lat);
    total++;
    if (lat !== 32) begin
      bad++;
      $display("FAIL basic_latency: got %0d want 32", lat);
    end
    total++;
    if (data_result !== 32'd12 || data_exception !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: res=%h exc=%b busy=%b want 0000000c 0 0",
               data_result, data_exception, busy);
    end
    @(negedge clock);
    total++;
    if (data_resultRDY !== 1'b0 || data_result !== 32'd12) begin
      bad++;
      $display("FAIL basic_after: rdy=%b res=%h want 0 0000000c", data_resultRDY, data_result);
    end
  endtask

  task automatic test_products();
    logic [31:0] va [5] = '{32'hFFFF_FFF9, 32'h7FFF_FFFF, 32'h0001_0000,
                            32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb [5] = '{32'd6, 32'hFFFF_FFFF, 32'h0001_0000,
                            32'hFFFF_FFFF, 32'd1};
    logic [31:0] vr [5] = '{32'hFFFF_FFD6, 32'h8000_0001, 32'h0000_0000,
                            32'h8000_0000, 32'h8000_0000};
    logic        ve [5] = '{1'b0, 1'b0, OVF_ON, OVF_ON, 1'b0};
    logic [31:0] prev;
    int lat;
    prev = 32'd12;
    for (int i = 0; i < 5; i++) begin
      do_start(va[i], vb[i]);
      total++;
      if (data_result !== prev) begin
        bad++;
        $display("FAIL prod%0d_hold: res=%h want %h", i, data_result, prev);
      end
      wait_rdy(lat);
      total++;
      if (lat !== 32 || data_result !== vr[i] || data_exception !== ve[i]) begin
        bad++;
        $display("FAIL prod%0d: lat=%0d res=%h exc=%b want 32 %h %b",
                 i, lat, data_result, data_exception, vr[i], ve[i]);
      end
      prev = vr[i];
      @(negedge clock);
    end
  endtask

  task automatic test_abort_restart();
    int lat;
    do_start(32'd5, 32'd5);
    repeat (9) @(negedge clock);
    do_start(32'd2, 32'd9);
    wait_rdy(lat);
    total++;
    if (lat !== 32 || data_result !== 32'd18) begin
      bad++;
      $display("FAIL abort_restart: lat=%0d res=%h want 32 00000012", lat, data_result);
    end
    @(negedge clock);
    total++;
    if (data_resultRDY !== 1'b0) begin
      bad++;
      $display("FAIL abort_single_rdy: rdy=%b want 0", data_resultRDY);
    end
  endtask

  task automatic test_restart_last();
    int lat;
    do_start(32'd5, 32'd5);
    repeat (31) @(negedge clock);
    do_start(32'd2, 32'd3);
    total++;
    if (data_resultRDY !== 1'b0 || data_result !== 32'd18 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_last: rdy=%b res=%h busy=%b want 0 00000012 1",
               data_resultRDY, data_result, busy);
    end
    wait_rdy(lat);
    total++;
    if (lat !== 32 || data_result !== 32'd6) begin
      bad++;
      $display("FAIL restart_last_result: lat=%0d res=%h want 32 00000006", lat, data_result);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int lat;
    do_start(32'd7, 32'd8);
    wait_rdy(lat);
    total++;
    if (lat !== 32 || data_result !== 32'd56) begin
      bad++;
      $display("FAIL b2b_first: lat=%0d res=%h want 32 00000038", lat, data_result);
    end
    do_start(32'hFFFF_FFFE, 32'd10);
    total++;
    if (data_resultRDY !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_start: rdy=%b busy=%b want 0 1", data_resultRDY, busy);
    end
    wait_rdy(lat);
    total++;
    if (lat !== 32 || data_result !== 32'hFFFF_FFEC) begin
      bad++;
      $display("FAIL b2b_second: lat=%0d res=%h want 32 ffffffec", lat, data_result);
    end
    @(negedge clock);
  endtask

  task automatic test_clr_mid_run();
    int lat;
    int rdy_seen;
    do_start(32'd5, 32'd5);
    repeat (14) @(negedge clock);
    clr_n = 1'b0;
    #1;
    total++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      bad++;
      $display("FAIL clr_async: res=%h exc=%b rdy=%b busy=%b want all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
    @(negedge clock);
    clr_n = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    total++;
    if (rdy_seen !== 0 || busy !== 1'b0 || data_result !== 32'd0) begin
      bad++;
      $display("FAIL clr_no_rdy: rdy_count=%0d busy=%b res=%h want 0 0 0",
               rdy_seen, busy, data_result);
    end
    do_start(32'd2, 32'd3);
    wait_rdy(lat);
    total++;
    if (lat !== 32 || data_result !== 32'd6) begin
      bad++;
      $display("FAIL clr_then_run: lat=%0d res=%h want 32 00000006", lat, data_result);
    end
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_basic();
    test_products();
    test_abort_restart();
    test_restart_last();
    test_back_to_back();
    test_clr_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
